// File: rtl/cla_mp_sequencer.sv
// Multi-precision add/subtract sequencer: time-shares one W-bit carry-lookahead adder
// across WORDS chunks, LSB first, with the inter-chunk carry held in a register.
module cla_mp_sequencer #(
    parameter int unsigned N     = 3,
    parameter int unsigned WORDS = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WORDS*(2**N)-1:0]     op_a,
    input  logic [WORDS*(2**N)-1:0]     op_b,
    input  logic                        sub,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WORDS*(2**N)-1:0]     result,
    output logic                        cout,
    output logic                        ovf
);

    localparam int unsigned W    = 2 ** N;
    localparam int unsigned IdxW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e                     state_q, state_d;
    logic   [IdxW-1:0]          idx_q;
    logic                       carry_q;
    logic   [WORDS-1:0][W-1:0]  opa_q;
    logic   [WORDS-1:0][W-1:0]  opb_q;
    logic   [WORDS-1:0][W-1:0]  result_q;
    logic                       cout_q;
    logic                       ovf_q;
    logic                       out_valid_q;

    logic                       last_chunk;
    logic   [W-1:0]             add_a;
    logic   [W-1:0]             add_b;
    logic   [W-1:0]             add_sum;
    logic                       add_cout;
    logic   [W:0]               carries;
    logic   [W-1:0]             grp_g [N+1];
    logic   [W-1:0]             grp_p [N+1];

    assign last_chunk = (idx_q == IdxW'(WORDS - 1));
    assign add_a      = opa_q[idx_q];
    assign add_b      = opb_q[idx_q];

    // Kogge-Stone prefix over the chunk: after N levels grp_g/grp_p[N][i] span bits i..0.
    always_comb begin
        grp_g[0] = add_a & add_b;
        grp_p[0] = add_a ^ add_b;
        for (int l = 0; l < N; l++) begin
            for (int i = 0; i < W; i++) begin
                if (i >= (1 << l)) begin
                    grp_g[l+1][i] = grp_g[l][i] | (grp_p[l][i] & grp_g[l][i-(1<<l)]);
                    grp_p[l+1][i] = grp_p[l][i] & grp_p[l][i-(1<<l)];
                end else begin
                    grp_g[l+1][i] = grp_g[l][i];
                    grp_p[l+1][i] = grp_p[l][i];
                end
            end
        end
        carries[0] = carry_q;
        for (int i = 0; i < W; i++) begin
            carries[i+1] = grp_g[N][i] | (grp_p[N][i] & carry_q);
        end
        add_sum  = grp_p[0] ^ carries[W-1:0];
        add_cout = carries[W];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (in_valid) state_d = StRun;
            StRun:   if (last_chunk) state_d = StDone;
            StDone:  if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == StIdle) && !rst;
        out_valid = out_valid_q;
        result    = result_q;
        cout      = cout_q;
        ovf       = ovf_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q       <= '0;
            carry_q     <= 1'b0;
            opa_q       <= '0;
            opb_q       <= '0;
            result_q    <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        opa_q   <= op_a;
                        opb_q   <= sub ? ~op_b : op_b;
                        carry_q <= sub;
                        idx_q   <= '0;
                    end
                end
                StRun: begin
                    result_q[idx_q] <= add_sum;
                    carry_q         <= add_cout;
                    if (last_chunk) begin
                        cout_q      <= add_cout;
                        ovf_q       <= (add_a[W-1] == add_b[W-1]) && (add_sum[W-1] != add_a[W-1]);
                        out_valid_q <= 1'b1;
                        idx_q       <= '0;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                StDone: begin
                    if (out_ready) out_valid_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/cla_mp_sequencer.md
Name: cla_mp_sequencer

Overview:
Multi-precision add/subtract controller. It time-shares one 2^N-bit carry-lookahead adder instance to add or subtract WORDS*2^N-bit operands, processing one chunk per cycle from LSB to MSB. The inter-chunk carry is held in a register between cycles. It sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.

Parameters:
N, 3, chunk width is W = 2**N bits. The same N is passed to the internal adder instance.
WORDS, 4, number of chunks per operand. Legal values are WORDS >= 2. Total operand width is WORDS*W.

Ports:
clk  input  1  single clock. All state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  operands and op are valid this cycle.
in_ready  output  1  block can accept a new operation.
op_a  input  WORDS*W  operand A.
op_b  input  WORDS*W  operand B.
sub  input  1  0 computes A+B. 1 computes A-B.
out_valid  output  1  result fields are valid.
out_ready  input  1  consumer accepts the result.
result  output  WORDS*W  sum or difference, modulo 2^(WORDS*W).
cout  output  1  carry out of the MSB chunk. For subtract, 1 means no borrow (A >= B unsigned).
ovf  output  1  two's-complement signed overflow.

Behaviour:
- Reset (rst=1 at a rising edge):
  - state goes to IDLE; chunk index = 0; carry register = 0.
  - out_valid = 0, result = 0, cout = 0, ovf = 0.
  - in_ready is 0 in any cycle where rst=1.
  - Reset takes priority over every other event.
- FSM states: IDLE, RUN, DONE.
- in_ready = (state==IDLE) && !rst. It is combinational from state.
- IDLE:
  - On in_valid && in_ready, latch opa_r = op_a and opb_r = sub ? ~op_b : op_b.
  - Set carry register = sub, idx = 0, then go to RUN.
  - op_a, op_b and sub are don't-care in every other cycle.
- RUN, one chunk per cycle:
  - Adder inputs: opa_r[idx*W +: W], opb_r[idx*W +: W], carry register.
  - Write the adder sum into result[idx*W +: W]; carry register <= adder cout; idx <= idx+1.
  - When idx == WORDS-1:
    - cout <= adder cout.
    - ovf <= (a_msb == b'_msb) && (s_msb != a_msb). Here a_msb, b'_msb and s_msb are bit W-1 of the current chunk inputs and sum (b' is the possibly inverted B).
    - Go to DONE.
- DONE:
  - out_valid = 1 (registered; set on the RUN→DONE edge).
  - result, cout and ovf hold stable while out_valid && !out_ready.
  - On out_valid && out_ready: out_valid <= 0 and go to IDLE.
- Latency: the acceptance edge is cycle 0. out_valid rises exactly WORDS edges later.
- Throughput: with out_ready held high, one operation every WORDS+2 cycles. in_ready rises the cycle after the result handshake.
- result chunks not yet written during RUN hold their previous value. Only the DONE-state values are architecturally visible.
- Boundary conditions:
  - in_valid asserted outside IDLE is ignored; no operand capture.
  - out_ready asserted outside DONE has no effect.
  - Reset mid-RUN or in DONE aborts the operation; no out_valid is produced.
  - idx wraps only via the RUN→DONE transition and is never incremented past WORDS-1.
  - Carry from the MSB chunk is never fed into a subsequent operation; the carry register is reloaded on every accept.
- The adder path is combinational from registers to the result/carry registers. There is one adder instance and no multi-cycle paths.

Test Plan:
- Reset (N=3, WORDS=4, 32-bit): hold rst for 2 cycles → in_ready=0, out_valid=0, result=0, cout=0, ovf=0. in_ready=1 on the first cycle after rst drops.
- Full ripple: sub=0, A=0xFFFFFFFF, B=0x00000001 → out_valid exactly 4 edges after accept; result=0x00000000, cout=1, ovf=0.
- Inter-chunk carry: sub=0, A=0x000000FF, B=0x00000001 → result=0x00000100, cout=0. Separately, A=0x7FFFFFFF, B=1 → result=0x80000000, ovf=1, cout=0.
- Subtract:
  - A=5, B=7 → result=0xFFFFFFFE, cout=0, ovf=0.
  - A=0x80000000, B=1 → result=0x7FFFFFFF, cout=1, ovf=1.
  - A=B=0x12345678 → result=0, cout=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands → result, cout and ovf stay stable, in_ready=0, no capture. Raise out_ready → next cycle in IDLE, in_ready=1, and the new operation is accepted.
- Reset mid-operation: assert rst during RUN when idx=2 → next cycle state=IDLE, out_valid=0, result=0. A following A=3, B=4 add returns 0x00000007.
